// File: rtl/pc_branch_ctrl_if.sv
// pc_branch_ctrl_if
// Bundles the instruction-side controls, comparator flags and PC/branch
// results exchanged with the PC and branch-resolution stage.
//   master : the upstream pipeline (drives instruction info, reads PC state)
//   slave  : pc_branch_ctrl itself
// Signals:
//   i_insn_vld, i_stall             advance qualifiers
//   i_branch, i_jal, i_jalr         control-transfer kind
//   i_funct3                        branch condition select
//   i_pc_target                     ALU-computed target address
//   i_br_less, i_br_equal           comparator flags
//   o_br_un                         comparator signed select (1 = signed)
//   o_pc, o_pc_plus4                current PC and its link value
//   o_taken                         control transfer taken this cycle
//   o_misalign, o_halted            trap status
//   o_br_cnt, o_br_taken_cnt        branch statistics
interface pc_branch_ctrl_if;
   logic        i_insn_vld;
   logic        i_stall;
   logic        i_branch;
   logic        i_jal;
   logic        i_jalr;
   logic [2:0]  i_funct3;
   logic [31:0] i_pc_target;
   logic        i_br_less;
   logic        i_br_equal;
   logic        o_br_un;
   logic [31:0] o_pc;
   logic [31:0] o_pc_plus4;
   logic        o_taken;
   logic        o_misalign;
   logic        o_halted;
   logic [31:0] o_br_cnt;
   logic [31:0] o_br_taken_cnt;

   modport master (
      output i_insn_vld, i_stall, i_branch, i_jal, i_jalr, i_funct3,
             i_pc_target, i_br_less, i_br_equal,
      input  o_br_un, o_pc, o_pc_plus4, o_taken, o_misalign, o_halted,
             o_br_cnt, o_br_taken_cnt
   );

   modport slave (
      input  i_insn_vld, i_stall, i_branch, i_jal, i_jalr, i_funct3,
             i_pc_target, i_br_less, i_br_equal,
      output o_br_un, o_pc, o_pc_plus4, o_taken, o_misalign, o_halted,
             o_br_cnt, o_br_taken_cnt
   );
endinterface

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl
// Program-counter and branch-resolution stage for the RV32I core. Drives the
// comparator's signed/unsigned select, resolves the branch condition from
// funct3 and the comparator flags, picks the next PC for PC+4, taken branch,
// JAL and JALR, and halts when a taken control transfer targets a
// non-4-byte-aligned address.
// Ports:
//   i_clk   core clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     pc_branch_ctrl_if.slave (see the interface file for signals)
// Parameters:
//   RESET_PC  PC loaded on reset; must be 4-byte aligned
// Optional feature macro:
//   BR_STATS_EN  when defined, keeps saturating counters of retired and
//                taken branches; otherwise both counter outputs read 0
module pc_branch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic             i_clk,
   input logic             i_rst,
   pc_branch_ctrl_if.slave bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        misalign_flag;
   logic        br_cond;
   logic        taken;
   logic [31:0] target;
   logic [31:0] pc_next;
   logic        advance;
   logic        misalign_now;

   // Branch condition decode. funct3 010/011 are not branch encodings, so
   // they resolve as never taken rather than borrowing another condition.
   always_comb begin
      br_cond = 1'b0;
      unique case (bus.i_funct3)
         3'b000:          br_cond = bus.i_br_equal;
         3'b001:          br_cond = ~bus.i_br_equal;
         3'b100, 3'b110:  br_cond = bus.i_br_less;
         3'b101, 3'b111:  br_cond = ~bus.i_br_less;
         default:         br_cond = 1'b0;
      endcase
   end

   // Target selection follows JALR > JAL > branch. Only JALR clears bit 0;
   // JAL and branches take the ALU target unchanged. Stall and valid do not
   // gate taken, so the upstream can see the redirect while holding.
   always_comb begin
      pc_plus4     = pc + 32'd4;
      target       = bus.i_jalr ? {bus.i_pc_target[31:1], 1'b0} : bus.i_pc_target;
      taken        = (state == RUN) &
                     (bus.i_jalr | bus.i_jal | (bus.i_branch & br_cond));
      pc_next      = taken ? target : pc_plus4;
      misalign_now = taken & target[1];
      advance      = (state == RUN) & bus.i_insn_vld & ~bus.i_stall;
   end

   // Next-state logic: a misaligned taken transfer on an advance cycle traps
   // into HALT, which is left only through reset.
   always_comb begin
      state_next = state;
      unique case (state)
         RUN:     if (advance && misalign_now) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = RUN;
      endcase
   end

   // State, PC and sticky misalign flag. The PC does not move on the
   // trapping cycle, so o_pc still points at the faulting instruction.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= RUN;
         pc            <= RESET_PC;
         misalign_flag <= 1'b0;
      end else begin
         state <= state_next;
         if (advance) begin
            if (misalign_now) begin
               misalign_flag <= 1'b1;
            end else begin
               pc <= pc_next;
            end
         end
      end
   end

`ifdef BR_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] br_taken_cnt;
   logic        br_retire;

   // A branch retires on an advance cycle when no jump overrides it and it
   // does not trap; a trapping branch never retires so it is not counted.
   always_comb begin
      br_retire = advance & bus.i_branch & ~bus.i_jal & ~bus.i_jalr & ~misalign_now;
   end

   // Saturating statistics counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         br_cnt       <= 32'd0;
         br_taken_cnt <= 32'd0;
      end else if (br_retire) begin
         if (br_cnt != 32'hFFFF_FFFF) begin
            br_cnt <= br_cnt + 32'd1;
         end
         if (taken && (br_taken_cnt != 32'hFFFF_FFFF)) begin
            br_taken_cnt <= br_taken_cnt + 32'd1;
         end
      end
   end

   assign bus.o_br_cnt       = br_cnt;
   assign bus.o_br_taken_cnt = br_taken_cnt;
`else
   assign bus.o_br_cnt       = 32'd0;
   assign bus.o_br_taken_cnt = 32'd0;
`endif

   // BLT/BGE are the only signed compares; BLTU/BGEU and equality use the
   // unsigned mode (equality is insensitive to it).
   assign bus.o_br_un    = (bus.i_funct3 == 3'b100) || (bus.i_funct3 == 3'b101);
   assign bus.o_pc       = pc;
   assign bus.o_pc_plus4 = pc_plus4;
   assign bus.o_taken    = taken;
   assign bus.o_misalign = misalign_flag;
   assign bus.o_halted   = (state == HALT);

endmodule

// File: doc/pc_branch_ctrl.md
# pc_branch_ctrl

Program-counter and branch-resolution stage for the RV32I core. Sits directly downstream of the branch comparator. It drives the comparator's signed/unsigned select, consumes the less/equal flags, and decodes the branch condition from funct3. It then selects and registers the next PC for PC+4, branch, JAL and JALR, and halts on a misaligned control-transfer target.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- i_clk  in  1  core clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_insn_vld  in  1  current instruction valid; PC advances only when high.
- i_stall  in  1  hold PC; overrides i_insn_vld.
- i_branch  in  1  current instruction is a conditional branch.
- i_jal  in  1  current instruction is JAL.
- i_jalr  in  1  current instruction is JALR.
- i_funct3  in  3  instruction funct3.
- i_pc_target  in  32  ALU-computed target (PC+imm, or rs1+imm for JALR).
- i_br_less  in  1  comparator less-than flag.
- i_br_equal  in  1  comparator equal flag.
- o_br_un  out  1  comparator mode select: 1 = signed, 0 = unsigned.
- o_pc  out  32  registered current PC.
- o_pc_plus4  out  32  o_pc + 4, for the link register.
- o_taken  out  1  control transfer taken this cycle (combinational).
- o_misalign  out  1  sticky instruction-address-misaligned flag.
- o_halted  out  1  high in HALT state.
- o_br_cnt  out  32  branches retired.
- o_br_taken_cnt  out  32  branches retired and taken.

## Operation
- o_br_un = 1 when i_funct3 is 100 or 101 (BLT, BGE); 0 otherwise.
- Branch condition by funct3:
  - 000: equal.
  - 001: not equal.
  - 100 and 110: less.
  - 101 and 111: not less.
  - 010 and 011: never taken.
- Priority: i_jalr > i_jal > i_branch.
  - JALR target = {i_pc_target[31:1], 1'b0}.
  - JAL target = i_pc_target.
  - Taken branch target = i_pc_target.
  - Otherwise next PC = o_pc + 4.
- o_taken = i_jalr | i_jal | (i_branch & condition). It is gated by state RUN only, not by stall or valid.
- Misalign rule: the selected target has bit 1 set (after the JALR bit-0 clear) and o_taken is high. No compressed-ISA support.
- State machine:
  - RUN → HALT on an advance cycle with the misalign rule true. In that cycle the PC is not updated and o_misalign sets.
  - HALT → HALT until i_rst; the PC is frozen and o_taken = 0.
- Arithmetic is 32-bit modulo. PC+4 from 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - o_pc = RESET_PC.
  - o_misalign = 0.
  - o_halted = 0.
  - Counters = 0.
  - State = RUN.
- Advance cycle: state RUN, i_insn_vld = 1, i_stall = 0. o_pc takes the next PC at that rising edge, giving 1-cycle latency.
- o_br_un, o_taken and o_pc_plus4 are combinational, valid in the same cycle as their inputs.
- Stall with a misaligned target: no trap. The check occurs only on advance cycles.
- i_rst asserted in any state, including HALT or mid-stall, wins at the next edge over all other inputs.

## Configuration
- BR_STATS_EN defined:
  - o_br_cnt increments on every advance cycle with i_branch = 1 and no jal or jalr.
  - o_br_taken_cnt increments on the subset of those cycles where the branch is taken.
  - A misaligned taken branch counts in neither counter.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- BR_STATS_EN undefined: the counter logic is removed and both ports are tied to 0. The ports remain so the interface is stable.

## Test plan
- Reset, then 3 valid non-branch cycles → o_pc: 0 → 4 → 8 → C; o_pc_plus4 tracks o_pc + 4.
- PC = 0x100, BLT (funct3 100), less = 1, target 0x80 → o_br_un = 1, o_taken = 1, next o_pc = 0x80. Repeat as BGEU (funct3 111) with less = 1 → o_br_un = 0, not taken, next o_pc = 0x104.
- JALR with target 0x201 → next o_pc = 0x200. Hold i_stall = 1 for 2 cycles first → PC is held and o_taken stays high.
- Taken BEQ with target 0x102 → o_misalign = 1 and o_halted = 1, PC stays at its prior value. Further valid cycles keep the PC frozen. i_rst = 1 → o_pc = RESET_PC, flags clear.
- funct3 010 with i_branch = 1 and equal = 1 → not taken, PC + 4. JAL and branch both high → JAL target is used.
- BR_STATS_EN defined: 5 branches with 3 taken → o_br_cnt = 5, o_br_taken_cnt = 3. With the macro undefined, both counters read 0.
